// File: rtl/sprint_input_pkg.sv
// Shared types and constants for the Sprint-family steering/gear input stages.
package sprint_input_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    DIGITAL,
    PADDLE
  } src_e;

  // Phase index to quadrature code; adjacent entries differ in exactly one bit.
  localparam logic [1:0] QUAD_GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/quad_phase_gen.sv
// Quadrature phase stepper: moves a 2-bit phase index one position per advance
// and presents it Gray-coded, with a one-cycle step pulse on each move.
module quad_phase_gen
  import sprint_input_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       dir,
  output logic [1:0] steer,
  output logic       step
);

  logic [1:0] idx_q;
  logic [1:0] idx_next;

  // Modulo-4 wrap is free from the 2-bit width, so 3->0 and 0->3 need no special case.
  assign idx_next = (dir == DIR_RIGHT) ? idx_q + 2'd1 : idx_q - 2'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      steer <= 2'b00;
      step  <= 1'b0;
    end else begin
      step <= advance;
      if (advance) begin
        idx_q <= idx_next;
        steer <= QUAD_GRAY[idx_next];
      end
    end
  end

endmodule

// File: rtl/paddle_steer_quad.sv
// Steering front end: turns left/right buttons or an absolute paddle position
// into a rate-limited quadrature stream emulating a continuous-rotation encoder.
module paddle_steer_quad
  import sprint_input_pkg::*;
#(
  parameter int DIG_DIV      = 22500,
  parameter int PAD_DIV      = 2250,
  parameter int PAD_DEADBAND = 1
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       paddle_en,
  input  logic [7:0] paddle,
  output logic [1:0] steer,
  output logic       step,
  output logic       dir,
  output logic       busy
);

  localparam logic [15:0] DIG_LIM = 16'(DIG_DIV - 1);
  localparam logic [15:0] PAD_LIM = 16'(PAD_DIV - 1);

  src_e        src_q;
  src_e        req_src;
  logic        req_dir;
  logic        req_dir_q;
  logic [15:0] div_q;
  logic [15:0] lim;
  logic [7:0]  pos_q;
  logic [7:0]  err;
  logic [7:0]  err_mag;
  logic        pad_req;
  logic        moving;
  logic        restart;
  logic        fire;
  logic        dir_q;
  logic        busy_q;

  // Modular distance; 0x80 has magnitude 128 and sign bit set, so it resolves left.
  assign err     = paddle - pos_q;
  assign err_mag = err[7] ? (~err + 8'd1) : err;
  assign pad_req = paddle_en && (err_mag > 8'(PAD_DEADBAND));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    req_src = IDLE;
    req_dir = DIR_LEFT;
    if (src_q == SYNC) begin
      req_src = IDLE;
    end else if (left ^ right) begin
      req_src = DIGITAL;
      req_dir = right ? DIR_RIGHT : DIR_LEFT;
    end else if (pad_req) begin
      req_src = PADDLE;
      req_dir = err[7] ? DIR_LEFT : DIR_RIGHT;
    end
  end

  assign moving  = (req_src == DIGITAL) || (req_src == PADDLE);
  assign restart = (req_src != src_q) || (req_dir != req_dir_q);
  assign lim     = (req_src == DIGITAL) ? DIG_LIM : PAD_LIM;
  assign fire    = moving && !restart && (div_q == lim);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      src_q     <= SYNC;
      req_dir_q <= DIR_LEFT;
      div_q     <= '0;
      pos_q     <= 8'd0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      src_q     <= req_src;
      req_dir_q <= req_dir;
      busy_q    <= moving;

      // A fresh request lands at 0, so the first edge comes a full period later.
      if (!moving || restart || fire) div_q <= '0;
      else                            div_q <= div_q + 16'd1;

      if (fire) dir_q <= req_dir;

      // Shadowing the paddle whenever it is not being tracked avoids a jump on switch-over.
      if (src_q == SYNC || req_src == DIGITAL || (req_src == IDLE && !paddle_en))
        pos_q <= paddle;
      else if (fire && req_src == PADDLE)
        pos_q <= (req_dir == DIR_RIGHT) ? pos_q + 8'd1 : pos_q - 8'd1;
    end
  end

  quad_phase_gen u_phase (
    .clk     (CLK),
    .rst_n   (Reset_n),
    .advance (fire),
    .dir     (req_dir),
    .steer   (steer),
    .step    (step)
  );

  assign dir  = dir_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_paddle_steer_quad.sv
// Directed bench for paddle_steer_quad: expected edges are queued per step and
// matched against step pulses by cycle offset, phase code and direction.
module tb_paddle_steer_quad;

  logic       CLK;
  logic       Reset_n;
  logic       left;
  logic       right;
  logic       paddle_en;
  logic [7:0] paddle;
  logic [1:0] steer;
  logic       step;
  logic       dir;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         offset;
    logic [1:0] steer;
    logic       dir;
  } ev_t;

  ev_t        sb[$];
  int         model_idx;
  logic [1:0] gray [4];

  paddle_steer_quad #(
    .DIG_DIV      (8),
    .PAD_DIV      (4),
    .PAD_DEADBAND (1)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .left      (left),
    .right     (right),
    .paddle_en (paddle_en),
    .paddle    (paddle),
    .steer     (steer),
    .step      (step),
    .dir       (dir),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_edge(input int offset, input logic d);
    ev_t e;
    model_idx = d ? (model_idx + 1) % 4 : (model_idx + 3) % 4;
    e.offset = offset;
    e.steer  = gray[model_idx];
    e.dir    = d;
    sb.push_back(e);
  endtask

  // Offset 0 is the first rising edge after the stimulus change.
  task automatic run_window(input string tag, input int n);
    logic [1:0] prev;
    ev_t        e;
    prev = steer;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (step) begin
        if (sb.size() == 0) begin
          check({tag, " unexpected_step"}, 32'(step), 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, " edge_offset"}, 32'(i), 32'(e.offset));
          check({tag, " steer"}, 32'(steer), 32'(e.steer));
          check({tag, " dir"}, 32'(dir), 32'(e.dir));
          check({tag, " one_bit_change"}, 32'($countones(steer ^ prev)), 32'd1);
        end
      end
      prev = steer;
    end
    check({tag, " missed_edges"}, 32'(sb.size()), 32'd0);
    sb.delete();
    check({tag, " steer_at_end"}, 32'(steer), 32'(gray[model_idx]));
  endtask

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    model_idx = 0;
    Reset_n   = 1'b0;
    left      = 1'b0;
    right     = 1'b0;
    paddle_en = 1'b1;
    paddle    = 8'h40;

    repeat (3) @(posedge CLK);
    #1;
    check("reset steer", 32'(steer), 32'd0);
    check("reset step",  32'(step),  32'd0);
    check("reset dir",   32'(dir),   32'd0);
    check("reset busy",  32'(busy),  32'd0);

    @(negedge CLK) Reset_n = 1'b1;
    run_window("idle_after_sync", 20);
    check("idle_after_sync busy", 32'(busy), 32'd0);

    @(negedge CLK) right = 1'b1;
    expect_edge(8, 1'b1); expect_edge(16, 1'b1); expect_edge(24, 1'b1); expect_edge(32, 1'b1);
    run_window("dig_right", 36);
    check("dig_right busy", 32'(busy), 32'd1);

    @(negedge CLK) begin left = 1'b1; right = 1'b1; end
    run_window("both_held", 20);
    check("both_held busy", 32'(busy), 32'd0);

    @(negedge CLK) begin left = 1'b0; right = 1'b0; paddle = 8'h43; end
    expect_edge(4, 1'b1); expect_edge(8, 1'b1);
    run_window("pad_small", 16);
    check("pad_small busy", 32'(busy), 32'd0);

    @(negedge CLK) paddle = 8'h47;
    run_window("rev_pre", 2);
    @(negedge CLK) paddle = 8'h3D;
    expect_edge(4, 1'b0); expect_edge(8, 1'b0); expect_edge(12, 1'b0); expect_edge(16, 1'b0);
    run_window("rev_post", 22);
    check("rev_post busy", 32'(busy), 32'd0);

    @(negedge CLK) begin paddle_en = 1'b0; paddle = 8'hFE; end
    run_window("resync", 3);
    @(negedge CLK) begin paddle_en = 1'b1; paddle = 8'h02; end
    expect_edge(4, 1'b1); expect_edge(8, 1'b1); expect_edge(12, 1'b1);
    run_window("wrap", 16);
    check("wrap busy", 32'(busy), 32'd0);

    @(negedge CLK) paddle = 8'h81;
    expect_edge(4, 1'b0); expect_edge(8, 1'b0);
    run_window("half_turn", 10);
    check("half_turn busy", 32'(busy), 32'd1);

    @(negedge CLK) begin paddle_en = 1'b0; left = 1'b1; end
    expect_edge(8, 1'b0);
    run_window("dig_left", 10);
    check("dig_left steer_11", 32'(steer), 32'd3);

    @(negedge CLK) Reset_n = 1'b0;
    #1;
    check("async_reset steer", 32'(steer), 32'd0);
    check("async_reset busy",  32'(busy),  32'd0);
    check("async_reset step",  32'(step),  32'd0);
    check("async_reset dir",   32'(dir),   32'd0);
    left      = 1'b0;
    paddle_en = 1'b1;
    paddle    = 8'h60;
    model_idx = 0;

    @(negedge CLK) Reset_n = 1'b1;
    run_window("post_reset", 12);
    check("post_reset busy", 32'(busy), 32'd0);

    @(negedge CLK) paddle = 8'h63;
    expect_edge(4, 1'b1); expect_edge(8, 1'b1);
    run_window("post_reset_pad", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
